// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the synchronous instruction memory, and holds the IF/ID register.
// Optional per-stage perf counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_instr,
    output logic               id_valid,
    output logic [31:0]        pc
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0]        perf_fetch,
    output logic [31:0]        perf_stall,
    output logic [31:0]        perf_flush
`endif
);

    localparam logic [31:0] BUBBLE = 32'h0000_0013;

    logic [31:0] pc_next;
    logic        unused_redirect_lsbs;

    // Branch/jal targets are word aligned; the low bits are dropped rather than trapped.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        pc_next = pc + 32'd4;
        if (rst)
            pc_next = RESET_PC;
        else if (redirect)
            pc_next = {redirect_pc[31:2], 2'b00};
        else if (stall)
            pc_next = pc;
    end

    // Addressing with pc_next makes the registered read data line up with pc next cycle.
    assign imem_addr = pc_next[IMEM_AW+1:2];

    always_ff @(posedge clk) begin
        pc <= pc_next;
    end

    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            id_instr <= BUBBLE;
            id_pc    <= 32'h0000_0000;
            id_valid <= 1'b0;
        end else if (!stall) begin
            id_instr <= imem_rdata;
            id_pc    <= pc;
            id_valid <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch <= 32'h0;
            perf_stall <= 32'h0;
            perf_flush <= 32'h0;
        end else if (redirect) begin
            perf_flush <= perf_flush + 32'd1;
        end else if (stall) begin
            perf_stall <= perf_stall + 32'd1;
        end else begin
            perf_fetch <= perf_fetch + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, stall, redirect, reset mid-stream, aliasing and PC wrap.
// Perf counters are checked when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid;
    logic [31:0] pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
`endif

    logic [31:0] mem [256];
    int n_cmp = 0;
    int n_bad = 0;
    int exp_fetch = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(8)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid), .pc(pc)
`ifdef FETCH_PERF_CNT_EN
       ,.perf_fetch(perf_fetch), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= mem[imem_addr];

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; the expected perf counts follow the inputs held across that edge.
    task automatic step();
        if (rst) begin
            exp_fetch = 0; exp_stall = 0; exp_flush = 0;
        end else if (redirect) exp_flush++;
        else if (stall) exp_stall++;
        else exp_fetch++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic [31:0] epc, input logic [31:0] einstr,
                          input logic evalid);
        chk({tag, "_id_pc"}, id_pc, epc);
        chk({tag, "_id_instr"}, id_instr, einstr);
        chk({tag, "_id_valid"}, {31'h0, id_valid}, {31'h0, evalid});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_8113;
        mem[2] = 32'h0020_81B3;
        mem[3] = 32'h0000_006F;
        mem[255] = 32'hDEAD_BEEF;

        // Reset state
        step(); step();
        chk_id("rst", 32'h0, 32'h13, 1'b0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_addr", {24'h0, imem_addr}, 32'd0);

        rst = 1'b0;
        #1;
        chk("rel_valid", {31'h0, id_valid}, 32'd0);
        chk("rel_pc", pc, 32'h0);
        chk("rel_addr", {24'h0, imem_addr}, 32'd1);

        step();
        chk_id("f0", 32'h0, 32'h0050_0093, 1'b1);
        chk("f0_pc", pc, 32'h4);
        chk("f0_addr", {24'h0, imem_addr}, 32'd2);
        step();
        chk_id("f1", 32'h4, 32'h0010_8113, 1'b1);
        chk("f1_addr", {24'h0, imem_addr}, 32'd3);

        // Three-cycle stall while ID holds pc=4
        stall = 1'b1;
        #1;
        chk("st_addr0", {24'h0, imem_addr}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_id("st", 32'h4, 32'h0010_8113, 1'b1);
            chk("st_pc", pc, 32'h8);
            chk("st_addr", {24'h0, imem_addr}, 32'd2);
        end
        stall = 1'b0;
        step();
        chk_id("post_st", 32'h8, 32'h0020_81B3, 1'b1);
        chk("post_st_addr", {24'h0, imem_addr}, 32'd4);
        step();
        chk_id("f3", 32'hC, 32'h0000_006F, 1'b1);
        chk("f3_pc", pc, 32'h10);

        // Reset pulse mid-stream with stall asserted
        rst = 1'b1; stall = 1'b1;
        step();
        chk_id("mrst", 32'h0, 32'h13, 1'b0);
        chk("mrst_pc", pc, 32'h0);
        chk("mrst_addr", {24'h0, imem_addr}, 32'd0);
        rst = 1'b0; stall = 1'b0;
        step();
        chk_id("mrst_f0", 32'h0, 32'h0050_0093, 1'b1);
        step();
        chk_id("mrst_f1", 32'h4, 32'h0010_8113, 1'b1);
        chk("mrst_pc8", pc, 32'h8);

        // Redirect to 0x20 while pc=8
        redirect = 1'b1; redirect_pc = 32'h20;
        #1;
        chk("rd_addr", {24'h0, imem_addr}, 32'd8);
        step();
        chk_id("rd_bub", 32'h0, 32'h13, 1'b0);
        chk("rd_pc", pc, 32'h20);
        redirect = 1'b0;
        step();
        chk_id("rd_tgt", 32'h20, 32'hA000_0008, 1'b1);
        chk("rd_pc2", pc, 32'h24);

        // Redirect and stall together
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h40;
        step();
        chk_id("rs_bub", 32'h0, 32'h13, 1'b0);
        chk("rs_pc", pc, 32'h40);
        redirect = 1'b0; stall = 1'b0;
        step();
        chk_id("rs_tgt", 32'h40, 32'hA000_0010, 1'b1);

        // Misaligned target has its low bits dropped
        redirect = 1'b1; redirect_pc = 32'h23;
        step();
        chk("mis_pc", pc, 32'h20);
        redirect = 1'b0;
        step();
        chk_id("mis_tgt", 32'h20, 32'hA000_0008, 1'b1);

        // Address aliasing above the memory range
        redirect = 1'b1; redirect_pc = 32'h400;
        #1;
        chk("alias_addr", {24'h0, imem_addr}, 32'd0);
        step();
        chk("alias_pc", pc, 32'h400);
        redirect = 1'b0;
        step();
        chk_id("alias_tgt", 32'h400, 32'h0050_0093, 1'b1);

        // PC wrap modulo 2^32
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        #1;
        chk("wrap_addr0", {24'h0, imem_addr}, 32'd255);
        step();
        redirect = 1'b0;
        #1;
        chk("wrap_addr1", {24'h0, imem_addr}, 32'd0);
        step();
        chk_id("wrap_id", 32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b1);
        chk("wrap_pc", pc, 32'h0);

`ifdef FETCH_PERF_CNT_EN
        // Fresh window: 10 free, 3 stalled, 1 redirect
        rst = 1'b1;
        step();
        chk("perf_rst", perf_fetch | perf_stall | perf_flush, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h80;
        step();
        redirect = 1'b0;
        chk("perf_stall", perf_stall, 32'd3);
        chk("perf_flush", perf_flush, 32'd1);
        chk("perf_fetch", perf_fetch, 32'd10);
        chk("perf_stall_m", perf_stall, 32'(exp_stall));
        chk("perf_fetch_m", perf_fetch, 32'(exp_fetch));
        chk("perf_flush_m", perf_flush, 32'(exp_flush));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
